// File: rtl/coding_pkg.sv
// Shared definitions for the coding-server client: data-width constants,
// the client FSM state type and the in-flight counter width helper.
package coding_pkg;

    localparam int BYTE = 8;
    localparam int WORD = 4 * BYTE;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } client_state_e;

    // Bits needed to hold a count from 0 up to max_outstanding inclusive.
    function automatic int ow_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/coding_resp_fifo.sv
// Response FIFO for the coding client: circular buffer with wrapping pointers,
// no bypass (a push becomes visible at the head on the following cycle).
module coding_resp_fifo
    import coding_pkg::*;
#(
    parameter int DATA_WIDTH = WORD,
    parameter int DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        push_data_i,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        head_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + AW'(1);
    endfunction

    assign do_pop      = pop_i && !empty_o;
    assign empty_o     = (count_reg == '0);
    assign full_o      = (count_reg == CW'(DEPTH));
    assign count_o     = count_reg;
    // The head is read straight from the array so a result is visible the
    // cycle after it is written, which the one-cycle result latency relies on.
    assign head_data_o = mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_reg] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_i, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    push_while_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));

endmodule

// File: rtl/coding_client.sv
// Initiator for the coding server's start/getResult interface with in-order
// response buffering and drain support. Optional watchdog: CODING_CLIENT_TIMEOUT_EN.
module coding_client
    import coding_pkg::*;
#(
    parameter int DATA_WIDTH      = WORD,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   req_valid_i,
    input  logic [DATA_WIDTH-1:0]                  req_data_i,
    output logic                                   req_ready_o,
    output logic                                   start_en_o,
    output logic [DATA_WIDTH-1:0]                  start_data_o,
    input  logic                                   start_rdy_i,
    output logic                                   getResult_en_o,
    input  logic                                   getResult_rdy_i,
    input  logic [DATA_WIDTH-1:0]                  getResult_data_i,
    output logic                                   resp_valid_o,
    output logic [DATA_WIDTH-1:0]                  resp_data_o,
    input  logic                                   resp_ready_i,
    input  logic                                   drain_i,
    output logic                                   drain_done_o,
    output logic [ow_width(MAX_OUTSTANDING)-1:0]   outstanding_o,
    output logic                                   error_o
);

    localparam int OW = ow_width(MAX_OUTSTANDING);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    generate
        if (MAX_OUTSTANDING < 1 || RESP_DEPTH < MAX_OUTSTANDING ||
            (RESP_DEPTH & (RESP_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("coding_client: illegal parameter combination");
        end
    endgenerate

    client_state_e  state_reg;
    logic [OW-1:0]  inflight_reg;
    logic [OW-1:0]  inflight_next;
    logic [CW-1:0]  fifo_cnt;
    logic [CW-1:0]  fifo_cnt_next;
    logic           fifo_full;
    logic           fifo_empty;
    logic           drain_done_reg;
    logic           error_reg;
    logic           error_next;
    logic           credit;
    logic           start_fire;
    logic           get_fire;
    logic           pop_fire;

    // Results still owed by the server plus results already buffered must
    // fit in the FIFO, so a getResult never finds it full.
    assign credit = (int'(inflight_reg) < MAX_OUTSTANDING) &&
                    (int'(inflight_reg) + int'(fifo_cnt) < RESP_DEPTH);

    // Method enables are gated by reset so nothing fires while rst_ni is low.
    assign req_ready_o    = rst_ni && (state_reg == ACTIVE) && start_rdy_i && credit;
    assign start_fire     = req_valid_i && req_ready_o;
    assign start_en_o     = start_fire;
    assign start_data_o   = req_data_i;
    assign get_fire       = rst_ni && getResult_rdy_i && (inflight_reg != '0) && !fifo_full;
    assign getResult_en_o = get_fire;
    assign resp_valid_o   = rst_ni && !fifo_empty;
    assign pop_fire       = resp_valid_o && resp_ready_i;
    assign outstanding_o  = inflight_reg;
    assign drain_done_o   = drain_done_reg;
    assign error_o        = error_reg;

    coding_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (get_fire),
        .push_data_i (getResult_data_i),
        .pop_i       (pop_fire),
        .head_data_o (resp_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    always_comb begin
        inflight_next = inflight_reg;
        case ({start_fire, get_fire})
            2'b10:   inflight_next = inflight_reg + OW'(1);
            2'b01:   inflight_next = inflight_reg - OW'(1);
            default: ;
        endcase
    end

    always_comb begin
        fifo_cnt_next = fifo_cnt;
        case ({get_fire, pop_fire})
            2'b10:   fifo_cnt_next = fifo_cnt + CW'(1);
            2'b01:   fifo_cnt_next = fifo_cnt - CW'(1);
            default: ;
        endcase
    end

`ifdef CODING_CLIENT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt_reg;
    logic          wd_tick;
    logic          wd_hit;

    // Counts cycles where the server owes results but none is collected.
    assign wd_tick    = (inflight_reg != '0) && !get_fire;
    assign wd_hit     = wd_tick && (wd_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
    assign error_next = error_reg || wd_hit;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wd_cnt_reg <= '0;
        end else if (!wd_tick) begin
            wd_cnt_reg <= '0;
        end else if (wd_cnt_reg != TW'(TIMEOUT_CYCLES)) begin
            wd_cnt_reg <= wd_cnt_reg + TW'(1);
        end
    end
`else
    assign error_next = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg      <= ACTIVE;
            inflight_reg   <= '0;
            drain_done_reg <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            inflight_reg   <= inflight_next;
            error_reg      <= error_next;
            drain_done_reg <= 1'b0;
            case (state_reg)
                ACTIVE: begin
                    if (drain_i) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A hung server would never empty, so an error ends the drain too.
                    if ((inflight_next == '0 && fifo_cnt_next == '0) || error_next) begin
                        state_reg      <= DONE;
                        drain_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= ACTIVE;
                end
                default: begin
                    state_reg <= ACTIVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coding_client.sv
// Directed bench for coding_client: a queue-based model is checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_coding_client;

    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam int DEPT = 4;
    localparam int TMO  = 8;
    localparam int OW   = $clog2(MAXO + 1);
    localparam logic [31:0] SRV_KEY = 32'h1234_56DD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          start_en;
    logic [DW-1:0] start_data;
    logic          start_rdy;
    logic          get_en;
    logic          get_rdy;
    logic [DW-1:0] get_data;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_ready;
    logic          drain;
    logic          drain_done;
    logic [OW-1:0] outstanding;
    logic          error;

    always #5 clk = ~clk;

    coding_client #(
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO),
        .RESP_DEPTH      (DEPT),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_data_i       (req_data),
        .req_ready_o      (req_ready),
        .start_en_o       (start_en),
        .start_data_o     (start_data),
        .start_rdy_i      (start_rdy),
        .getResult_en_o   (get_en),
        .getResult_rdy_i  (get_rdy),
        .getResult_data_i (get_data),
        .resp_valid_o     (resp_valid),
        .resp_data_o      (resp_data),
        .resp_ready_i     (resp_ready),
        .drain_i          (drain),
        .drain_done_o     (drain_done),
        .outstanding_o    (outstanding),
        .error_o          (error)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: results owed by the server, results buffered, drain flags, error.
    logic [31:0] m_inflight[$];
    logic [31:0] m_fifo[$];
    logic [31:0] srv_q[$];
    bit          m_draining = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
`ifdef CODING_CLIENT_TIMEOUT_EN
    int          m_wd = 0;
`endif

    function automatic logic [31:0] srv_f(input logic [31:0] x);
        return x ^ SRV_KEY;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_and_update();
        int n_in;
        int n_f;
        bit active, e_rr, e_st, e_gr, e_rv, pop, gr_idle;
        n_in   = m_inflight.size();
        n_f    = m_fifo.size();
        active = !m_draining && !m_done;
        e_rr   = rst_n && active && start_rdy && (n_in < MAXO) && (n_in + n_f < DEPT);
        e_st   = e_rr && req_valid;
        e_gr   = rst_n && get_rdy && (n_in != 0) && (n_f < DEPT);
        e_rv   = rst_n && (n_f != 0);
        chk("req_ready", req_ready, e_rr);
        chk("start_en", start_en, e_st);
        if (e_st) chk("start_data", start_data, req_data);
        chk("getResult_en", get_en, e_gr);
        chk("resp_valid", resp_valid, e_rv);
        if (e_rv) chk("resp_data", resp_data, m_fifo[0]);
        chk("outstanding", outstanding, n_in);
        chk("drain_done", drain_done, m_done);
        chk("error", error, m_err);
        // bench-side server reacts to what the DUT actually does
        if (!rst_n) begin
            srv_q.delete();
        end else begin
            if (get_en && srv_q.size() != 0) void'(srv_q.pop_front());
            if (start_en) srv_q.push_back(srv_f(req_data));
        end
        if (!rst_n) begin
            m_inflight.delete();
            m_fifo.delete();
            m_draining = 1'b0;
            m_done = 1'b0;
            m_err = 1'b0;
`ifdef CODING_CLIENT_TIMEOUT_EN
            m_wd = 0;
`endif
        end else begin
            pop     = e_rv && resp_ready;
            gr_idle = (n_in != 0) && !e_gr;
            if (pop) void'(m_fifo.pop_front());
            if (e_gr) m_fifo.push_back(m_inflight.pop_front());
            if (e_st) m_inflight.push_back(srv_f(req_data));
`ifdef CODING_CLIENT_TIMEOUT_EN
            m_wd = gr_idle ? m_wd + 1 : 0;
            if (m_wd >= TMO) m_err = 1'b1;
`else
            if (gr_idle && m_err) m_err = 1'b1;
`endif
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_draining) begin
                if ((m_inflight.size() == 0 && m_fifo.size() == 0) || m_err) begin
                    m_draining = 1'b0;
                    m_done = 1'b1;
                end
            end else if (drain) begin
                m_draining = 1'b1;
            end
        end
    endtask

    // One clock: check at the falling edge, then move inputs 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_and_update();
        @(posedge clk);
        #1;
        get_data = (srv_q.size() != 0) ? srv_q[0] : '0;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_data = '0; start_rdy = 1'b1;
        get_rdy = 1'b0; resp_ready = 1'b0; drain = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] items [6];
        int idx, starts, pops, done_cnt;
        items = '{32'h0000_0001, 32'h0000_0022, 32'h0000_0333,
                  32'h0000_4444, 32'h0005_5555, 32'h0066_6666};

        rst_n = 1'b0; get_data = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_drain_done", drain_done, 0);
        chk("rst_error", error, 0);

        // 1: single operation
        req_valid = 1'b1; req_data = 32'h0000_00A5;
        #1;
        chk("t1_start_en", start_en, 1);
        chk("t1_start_data", start_data, 32'h0000_00A5);
        tick();
        req_valid = 1'b0; get_rdy = 1'b1;
        #1;
        chk("t1_get_en", get_en, 1);
        chk("t1_resp_valid_early", resp_valid, 0);
        tick();
        get_rdy = 1'b0;
        #1;
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp_data", resp_data, 32'h1234_5678);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // 2: back-pressure, six requests, server always ready
        idx = 0; starts = 0; pops = 0;
        get_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_valid = (idx < 6);
            req_data  = (idx < 6) ? items[idx] : '0;
            #1;
            if (req_valid && req_ready) begin idx++; starts++; end
            tick();
        end
        #1;
        chk("t2_starts_blocked", starts, 4);
        chk("t2_req_ready_low", req_ready, 0);
        chk("t2_outstanding", outstanding, 0);
        resp_ready = 1'b1;
        for (int c = 0; c < 40 && pops < 6; c++) begin
            req_valid = (idx < 6);
            req_data  = (idx < 6) ? items[idx] : '0;
            #1;
            if (req_valid && req_ready) begin idx++; starts++; end
            if (resp_valid) begin
                chk("t2_order", resp_data, items[pops] ^ SRV_KEY);
                pops++;
            end
            tick();
        end
        chk("t2_pops", pops, 6);
        chk("t2_starts", starts, 6);
        idle();

        // 3: simultaneous start and getResult at outstanding=2
        req_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_data = 32'h100 + k;
            tick();
        end
        req_data = 32'h300; get_rdy = 1'b1; resp_ready = 1'b1;
        #1;
        chk("t3_start_en", start_en, 1);
        chk("t3_get_en", get_en, 1);
        chk("t3_outstanding_before", outstanding, 2);
        tick();
        req_valid = 1'b0; get_rdy = 1'b0;
        #1;
        chk("t3_outstanding_after", outstanding, 2);
        get_rdy = 1'b1;
        repeat (6) tick();
        #1;
        chk("t3_outstanding_final", outstanding, 0);
        idle();

        // 4: drain with three in flight
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_data = 32'h400 + k;
            tick();
        end
        req_valid = 1'b0; drain = 1'b1;
        #1;
        chk("t4_ready_before", req_ready, 1);
        tick();
        drain = 1'b0;
        #1;
        chk("t4_ready_dropped", req_ready, 0);
        chk("t4_outstanding", outstanding, 3);
        get_rdy = 1'b1; resp_ready = 1'b1; done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (drain_done) begin
                done_cnt++;
                chk("t4_done_outstanding", outstanding, 0);
                chk("t4_done_resp_valid", resp_valid, 0);
            end
            tick();
            #1;
        end
        chk("t4_done_pulses", done_cnt, 1);
        idle();

        // drain while idle: ACTIVE -> DRAIN -> DONE -> ACTIVE
        drain = 1'b1;
        tick();
        drain = 1'b0;
        #1;
        chk("idle_drain_ready", req_ready, 0);
        chk("idle_drain_done0", drain_done, 0);
        tick();
        #1;
        chk("idle_drain_done1", drain_done, 1);
        tick();
        #1;
        chk("idle_drain_done2", drain_done, 0);
        chk("idle_drain_active", req_ready, 1);

        // 5: reset with two in flight and one queued
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_data = 32'h500 + k;
            tick();
        end
        req_valid = 1'b0; get_rdy = 1'b1;
        tick();
        get_rdy = 1'b0;
        #1;
        chk("t5_outstanding_pre", outstanding, 2);
        chk("t5_resp_valid_pre", resp_valid, 1);
        rst_n = 1'b0; req_valid = 1'b1; get_rdy = 1'b1;
        #1;
        chk("t5_start_gated", start_en, 0);
        chk("t5_get_gated", get_en, 0);
        tick();
        rst_n = 1'b1; req_valid = 1'b0; get_rdy = 1'b0;
        #1;
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_outstanding", outstanding, 0);
        chk("t5_active", req_ready, 1);

        // 6: server never returns a result
        req_valid = 1'b1; req_data = 32'h600;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            #1;
`ifdef CODING_CLIENT_TIMEOUT_EN
            chk("t6_error", error, (k >= TMO) ? 1 : 0);
`else
            chk("t6_error", error, 0);
`endif
        end
        drain = 1'b1;
        tick();
        drain = 1'b0;
        tick();
        #1;
`ifdef CODING_CLIENT_TIMEOUT_EN
        chk("t6_drain_on_error", drain_done, 1);
`else
        chk("t6_drain_stuck", drain_done, 0);
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_error_cleared", error, 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
